pkt_dispatch_sched: RTL and testbench
=====================================

// Module: pkt_dispatch_sched
// PURPOSE
//  Receives decoded packet descriptors, queues them, and sequences the enables to
//  myNodeInfo (MNI), knownCH (KCH), QTableUpdate (QTU) and reward blocks.
//  Each packet runs its enabled stages one at a time, waiting on each stage's done.
//  Fixed stage order: MNI -> KCH -> QTU -> REWARD.
//  Sits between the packet decoder and the per-node state and reward blocks.
// PARAMETERS
//  FIFO_DEPTH  4    descriptor queue entries (power of 2, >=2)
//  TIMEOUT     255  max cycles to wait for a stage done before abandoning that stage
//  ID_W        16   node ID width
// PORTS
//  clk          in   1     single clock
//  rst          in   1     synchronous, active-high reset
//  pkt_valid    in   1     descriptor offered
//  pkt_ready    out  1     descriptor accepted when valid&ready
//  pkt_type     in   3     packet type code
//  dest_id      in   ID_W  packet destinationID
//  my_node_id   in   ID_W  own node ID, sampled at dequeue
//  en_mni       out  1     1-cycle enable pulse to myNodeInfo
//  en_kch       out  1     1-cycle enable pulse to knownCH
//  en_qtu       out  1     1-cycle enable pulse to QTableUpdate
//  en_reward    out  1     1-cycle enable pulse to reward
//  mni_done     in   1     stage-complete pulse
//  kch_done     in   1     stage-complete pulse
//  qtu_done     in   1     stage-complete pulse
//  reward_done  in   1     stage-complete pulse
//  i_am_dest    out  1     held for whole packet: dest_id==my_node_id
//  recluster    out  1     1-cycle pulse when an SOS packet is dequeued
//  busy         out  1     FSM not IDLE or FIFO non-empty
//  err_timeout  out  1     sticky; set on any stage timeout; cleared only by rst
//  drop_cnt     out  8     count of type-111 packets dropped; saturates at 255
// BEHAVIOUR
//  Reset: FIFO empty, FSM=IDLE, all outputs 0, pkt_ready=1 the cycle after rst drops.
//  FIFO: pkt_ready = !full; no bypass. Push and pop in the same cycle are legal.
//   When full, a same-cycle pop does not raise ready in that cycle.
//  Stage mask per type ({REW,QTU,KCH,MNI}):
//   000 HB   MNI,REW     001 CHE  MNI,KCH     010 INV  KCH,REW     011 MR  QTU,REW
//   100 CHT  MNI,REW     101 DATA QTU, REW only if i_am_dest
//   110 SOS  as DATA, plus the recluster pulse
//   111      empty mask: dropped at LOAD, drop_cnt++, FSM returns to IDLE
//  FSM:
//   IDLE  -> LOAD when FIFO is non-empty
//   LOAD  pops the FIFO, latches mask and i_am_dest, then goes to ISSUE
//         (or IDLE if the mask is empty)
//   ISSUE pulses the lowest pending stage's enable for exactly 1 cycle,
//         clears the timer, then goes to WAIT
//   WAIT  on the matching done: clear that mask bit; go to ISSUE if bits
//         remain, else IDLE
//   WAIT  on timer==TIMEOUT: set err_timeout, clear that bit, same transitions
//  Latency: a descriptor accepted in cycle N into an empty FIFO with FSM idle
//   gives LOAD at N+1 and the first enable at N+2.
//  Back-to-back: last done at cycle M, IDLE at M+1, next LOAD at M+1 if queued.
//  Done handling: a done for a stage other than the one in WAIT is ignored.
//   A done in the same cycle as timer==TIMEOUT counts as success (no error).
//  At most one en_* output is high in any cycle. i_am_dest is 0 in IDLE.
//  Timer is 8 bits wide and cannot wrap, because it stops at TIMEOUT.
//  drop_cnt holds at 255.
//  rst mid-packet: immediate return to reset state; queued descriptors are lost;
//   no further enables are issued.
// STRUCTURE
//  Shared package pkt_defs_pkg:
//   - PKT_HB..PKT_RSV type codes
//   - STG_MNI/KCH/QTU/REW mask bit indices
//   - state enum (IDLE, LOAD, ISSUE, WAIT)
//  Sub-module: pkt_desc_fifo (3+ID_W wide, FIFO_DEPTH deep, full/empty flags).
//  The mask lookup and FSM stay in this module.
// TESTING
//  1. HB (000), dones returned 3 cycles after each enable
//     -> en_mni at N+2, then en_reward after mni_done; i_am_dest=0.
//  2. DATA (101) with dest_id==my_node_id=16'h0005
//     -> en_qtu then en_reward; i_am_dest=1 throughout.
//     Same packet with dest_id=16'h0007 -> en_qtu only.
//  3. SOS (110) -> recluster pulses in the LOAD cycle; otherwise behaves as DATA.
//     Type 111 -> no enables; drop_cnt 0->1.
//  4. Push 5 packets back-to-back while qtu_done is withheld
//     -> pkt_ready falls after 4 accepted; all 5 packets are processed in order.
//  5. Withhold kch_done on a CHE packet
//     -> err_timeout set exactly TIMEOUT cycles after WAIT entry; FSM returns to IDLE.
//     A stray mni_done during that WAIT is ignored.
//  6. Assert rst while in WAIT with 2 packets queued
//     -> all outputs 0 the next cycle; no enables afterwards; busy=0.

Source files
------------

// File: rtl/pkt_defs_pkg.sv
// Shared definitions for the packet dispatch scheduler: packet type codes,
// stage mask bit positions, scheduler state encoding and mask helpers.
package pkt_defs_pkg;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_INV  = 3'b010;
    localparam logic [2:0] PKT_MR   = 3'b011;
    localparam logic [2:0] PKT_CHT  = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;
    localparam logic [2:0] PKT_SOS  = 3'b110;
    localparam logic [2:0] PKT_RSV  = 3'b111;

    // Stage bit positions; lower index runs first.
    localparam int unsigned STG_MNI = 0;
    localparam int unsigned STG_KCH = 1;
    localparam int unsigned STG_QTU = 2;
    localparam int unsigned STG_REW = 3;
    localparam int unsigned NUM_STG = 4;

    typedef logic [NUM_STG-1:0] stg_mask_t;
    typedef logic [1:0]         stg_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT
    } sched_state_t;

    // Stages a packet type must visit; REW for DATA/SOS depends on destination.
    function automatic stg_mask_t stage_mask(input logic [2:0] ptype, input logic iad);
        stg_mask_t m;
        m = '0;
        case (ptype)
            PKT_HB, PKT_CHT: begin
                m[STG_MNI] = 1'b1;
                m[STG_REW] = 1'b1;
            end
            PKT_CHE: begin
                m[STG_MNI] = 1'b1;
                m[STG_KCH] = 1'b1;
            end
            PKT_INV: begin
                m[STG_KCH] = 1'b1;
                m[STG_REW] = 1'b1;
            end
            PKT_MR: begin
                m[STG_QTU] = 1'b1;
                m[STG_REW] = 1'b1;
            end
            PKT_DATA, PKT_SOS: begin
                m[STG_QTU] = 1'b1;
                m[STG_REW] = iad;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Index of the lowest pending stage (result is don't-care for an empty mask).
    function automatic stg_idx_t lowest_stage(input stg_mask_t m);
        stg_idx_t idx;
        casez (m)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic stg_mask_t stage_bit(input stg_idx_t idx);
        return stg_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/pkt_desc_fifo.sv
// Descriptor queue: synchronous FIFO with full/empty flags, no bypass.
// Writes are dropped when full, reads are ignored when empty.
module pkt_desc_fifo
    import pkt_defs_pkg::*;
#(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are meaningless while empty so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pkt_dispatch_sched.sv
// Packet dispatch scheduler: queues decoded descriptors and walks each packet
// through its enabled stages (MNI -> KCH -> QTU -> REWARD), one at a time,
// issuing a 1-cycle enable and waiting for the stage done or a timeout.
module pkt_dispatch_sched
    import pkt_defs_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned ID_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pkt_valid,
    output logic            pkt_ready,
    input  logic [2:0]      pkt_type,
    input  logic [ID_W-1:0] dest_id,
    input  logic [ID_W-1:0] my_node_id,
    output logic            en_mni,
    output logic            en_kch,
    output logic            en_qtu,
    output logic            en_reward,
    input  logic            mni_done,
    input  logic            kch_done,
    input  logic            qtu_done,
    input  logic            reward_done,
    output logic            i_am_dest,
    output logic            recluster,
    output logic            busy,
    output logic            err_timeout,
    output logic [7:0]      drop_cnt
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    sched_state_t    state;
    stg_mask_t       mask;
    stg_idx_t        cur_stg;
    logic [7:0]      timer;
    stg_mask_t       en_vec;
    logic            rdy_en;

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [2:0]      head_type;
    logic [ID_W-1:0] head_dest;

    logic            ld_iad;
    stg_mask_t       ld_mask;
    stg_mask_t       done_vec;
    logic            cur_done;
    stg_mask_t       mask_rem;
    logic            more_queued;

    // rdy_en keeps ready low during reset and for the first cycle after it.
    assign pkt_ready   = rdy_en && !fifo_full;
    assign push        = pkt_valid && pkt_ready;
    assign pop         = (state == LOAD);
    assign more_queued = !fifo_empty || push;

    pkt_desc_fifo #(
        .WIDTH (3 + ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({pkt_type, dest_id}),
        .pop   (pop),
        .rdata ({head_type, head_dest}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ld_iad   = (head_dest == my_node_id);
    assign ld_mask  = stage_mask(head_type, ld_iad);
    assign done_vec = {reward_done, qtu_done, kch_done, mni_done};
    assign cur_done = done_vec[cur_stg];
    assign mask_rem = mask & ~stage_bit(cur_stg);

    assign en_mni    = en_vec[STG_MNI];
    assign en_kch    = en_vec[STG_KCH];
    assign en_qtu    = en_vec[STG_QTU];
    assign en_reward = en_vec[STG_REW];
    assign recluster = (state == LOAD) && (head_type == PKT_SOS);
    assign busy      = (state != IDLE) || !fifo_empty;

    // Scheduler FSM with registered enables, destination flag and status.
    // The enable for a stage is loaded on the edge entering ISSUE so it is
    // high exactly during the ISSUE cycle; finishing a packet with work queued
    // goes straight to LOAD so the next packet starts the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mask        <= '0;
            cur_stg     <= '0;
            timer       <= '0;
            en_vec      <= '0;
            rdy_en      <= 1'b0;
            i_am_dest   <= 1'b0;
            err_timeout <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            rdy_en <= 1'b1;
            en_vec <= '0;
            case (state)
                IDLE: begin
                    if (more_queued) state <= LOAD;
                end
                LOAD: begin
                    if (ld_mask == '0) begin
                        i_am_dest <= 1'b0;
                        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                        state <= IDLE;
                    end else begin
                        mask      <= ld_mask;
                        i_am_dest <= ld_iad;
                        cur_stg   <= lowest_stage(ld_mask);
                        en_vec    <= stage_bit(lowest_stage(ld_mask));
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cur_done || timer == TMO) begin
                        if (!cur_done) err_timeout <= 1'b1;
                        mask <= mask_rem;
                        if (mask_rem != '0) begin
                            cur_stg <= lowest_stage(mask_rem);
                            en_vec  <= stage_bit(lowest_stage(mask_rem));
                            state   <= ISSUE;
                        end else begin
                            i_am_dest <= 1'b0;
                            state     <= more_queued ? LOAD : IDLE;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_dispatch_sched.sv
// Scoreboard bench for pkt_dispatch_sched: each packet sent pushes its expected
// stage enables into a queue; a monitor pops and compares on every enable pulse.
module tb_pkt_dispatch_sched;

    localparam int unsigned TMO  = 40;
    localparam int unsigned ID_W = 16;

    localparam logic [2:0] T_HB = 3'b000, T_CHE = 3'b001, T_INV = 3'b010, T_MR = 3'b011;
    localparam logic [2:0] T_CHT = 3'b100, T_DATA = 3'b101, T_SOS = 3'b110, T_RSV = 3'b111;
    localparam logic [1:0] S_MNI = 2'd0, S_KCH = 2'd1, S_QTU = 2'd2, S_REW = 2'd3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pkt_valid = 1'b0;
    logic            pkt_ready;
    logic [2:0]      pkt_type = '0;
    logic [ID_W-1:0] dest_id = '0;
    logic [ID_W-1:0] my_node_id = 16'h0005;
    logic            en_mni, en_kch, en_qtu, en_reward;
    logic            mni_done, kch_done, qtu_done, reward_done;
    logic            i_am_dest, recluster, busy, err_timeout;
    logic [7:0]      drop_cnt;

    logic [2:0] h_mni = '0, h_kch = '0, h_qtu = '0, h_rew = '0;
    logic hold_kch = 1'b0, hold_qtu = 1'b0, stray_mni = 1'b0, kick_qtu = 1'b0;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [1:0] stg;
        logic       iad;
    } exp_t;
    exp_t exp_q[$];

    pkt_dispatch_sched #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (TMO),
        .ID_W       (ID_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_type    (pkt_type),
        .dest_id     (dest_id),
        .my_node_id  (my_node_id),
        .en_mni      (en_mni),
        .en_kch      (en_kch),
        .en_qtu      (en_qtu),
        .en_reward   (en_reward),
        .mni_done    (mni_done),
        .kch_done    (kch_done),
        .qtu_done    (qtu_done),
        .reward_done (reward_done),
        .i_am_dest   (i_am_dest),
        .recluster   (recluster),
        .busy        (busy),
        .err_timeout (err_timeout),
        .drop_cnt    (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stage models: answer each enable with a done 3 cycles later unless withheld.
    always @(posedge clk) begin
        h_mni <= {h_mni[1:0], en_mni};
        h_kch <= {h_kch[1:0], en_kch};
        h_qtu <= {h_qtu[1:0], en_qtu};
        h_rew <= {h_rew[1:0], en_reward};
    end
    assign mni_done    = h_mni[2] | stray_mni;
    assign kch_done    = h_kch[2] & !hold_kch;
    assign qtu_done    = (h_qtu[2] & !hold_qtu) | kick_qtu;
    assign reward_done = h_rew[2];

    function automatic void check(input string name, input int act, input int req);
        tot_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    function automatic void expect_stg(input logic [1:0] s, input logic iad);
        exp_t e;
        e.stg = s;
        e.iad = iad;
        exp_q.push_back(e);
    endfunction

    // Monitor: every enable pulse is checked against the scoreboard head.
    initial begin
        logic [3:0] v;
        logic [1:0] s;
        exp_t       e;
        forever begin
            @(negedge clk);
            v = {en_reward, en_qtu, en_kch, en_mni};
            if (v != 4'b0000) begin
                check("en_onehot", $countones(v), 1);
                s = v[0] ? S_MNI : v[1] ? S_KCH : v[2] ? S_QTU : S_REW;
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_en: got stage %0d expected no enable (cycle %0d)", s, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("en_stage", s, e.stg);
                    check("en_iad", i_am_dest, e.iad);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [2:0] t, input logic [ID_W-1:0] d);
        int n = 0;
        pkt_type  = t;
        dest_id   = d;
        pkt_valid = 1'b1;
        while (!pkt_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", pkt_ready, 1);
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic wait_en(input int idx);
        int n = 0;
        logic [3:0] v;
        v = {en_reward, en_qtu, en_kch, en_mni};
        while (!v[idx] && n < 30) begin
            @(negedge clk);
            n++;
            v = {en_reward, en_qtu, en_kch, en_mni};
        end
        check("wait_en", v[idx], 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle", busy, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"},
              {pkt_ready, en_mni, en_kch, en_qtu, en_reward, i_am_dest, recluster, busy, err_timeout}, 0);
        check({name, "_drop"}, drop_cnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", pkt_ready, 1);

        // 1: HB, first enable two cycles after accept
        expect_stg(S_MNI, 1'b0);
        expect_stg(S_REW, 1'b0);
        send(T_HB, 16'h0009);
        check("hb_load_no_en", en_mni, 0);
        check("hb_busy", busy, 1);
        check("hb_no_recluster", recluster, 0);
        @(negedge clk);
        check("hb_en_mni_n2", en_mni, 1);
        wait_idle();

        // 2: DATA to self, then DATA elsewhere
        expect_stg(S_QTU, 1'b1);
        expect_stg(S_REW, 1'b1);
        send(T_DATA, 16'h0005);
        wait_idle();
        check("iad_idle", i_am_dest, 0);
        expect_stg(S_QTU, 1'b0);
        send(T_DATA, 16'h0007);
        wait_idle();

        // 3: SOS pulses recluster in LOAD; type 111 is dropped
        expect_stg(S_QTU, 1'b1);
        expect_stg(S_REW, 1'b1);
        send(T_SOS, 16'h0005);
        check("sos_recluster", recluster, 1);
        @(negedge clk);
        check("sos_recluster_end", recluster, 0);
        wait_idle();
        send(T_RSV, 16'h0005);
        wait_idle();
        check("drop_cnt_1", drop_cnt, 1);

        // 4: fill the queue while qtu_done is withheld
        hold_qtu = 1'b1;
        expect_stg(S_QTU, 1'b0);
        expect_stg(S_REW, 1'b0);
        send(T_MR, 16'h0009);
        wait_en(2);
        @(negedge clk);
        expect_stg(S_MNI, 1'b0); expect_stg(S_REW, 1'b0);
        send(T_HB, 16'h0009);
        expect_stg(S_MNI, 1'b0); expect_stg(S_KCH, 1'b0);
        send(T_CHE, 16'h0009);
        expect_stg(S_KCH, 1'b0); expect_stg(S_REW, 1'b0);
        send(T_INV, 16'h0009);
        expect_stg(S_MNI, 1'b0); expect_stg(S_REW, 1'b0);
        send(T_CHT, 16'h0009);
        check("ready_full", pkt_ready, 0);
        kick_qtu = 1'b1;
        @(negedge clk);
        kick_qtu = 1'b0;
        hold_qtu = 1'b0;
        expect_stg(S_QTU, 1'b0);
        send(T_DATA, 16'h0007);
        wait_idle();
        check("no_err_t4", err_timeout, 0);

        // 5: kch_done withheld -> timeout; stray mni_done ignored
        hold_kch = 1'b1;
        expect_stg(S_MNI, 1'b0);
        expect_stg(S_KCH, 1'b0);
        send(T_CHE, 16'h0009);
        wait_en(1);
        repeat (3) @(negedge clk);
        stray_mni = 1'b1;
        @(negedge clk);
        stray_mni = 1'b0;
        repeat (TMO + 1 - 4) @(negedge clk);
        check("tmo_err_before", err_timeout, 0);
        check("tmo_busy_before", busy, 1);
        @(negedge clk);
        check("tmo_err_set", err_timeout, 1);
        check("tmo_idle", busy, 0);
        hold_kch = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", err_timeout, 1);

        // 6: reset while waiting with two packets queued
        hold_qtu = 1'b1;
        expect_stg(S_QTU, 1'b0);
        send(T_MR, 16'h0009);
        wait_en(2);
        @(negedge clk);
        send(T_HB, 16'h0009);
        send(T_HB, 16'h0009);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", pkt_ready, 1);
        repeat (20) @(negedge clk);
        check("midrst_busy", busy, 0);
        hold_qtu = 1'b0;

        check("exp_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
